addsub_seq: RTL

- Parametrised, multi-cycle two's-complement adder/subtractor; successor to the fixed 4-bit ripple add/sub path.
- Processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, with a carry register between slices.
- Adds a per-operation mode select, status flags and valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer in the datapath.

---
 rtl/addsub_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor. It processes one CHUNK-bit slice
// per clock and keeps a carry register between slices. Valid/ready handshakes on both sides.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] result_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic [CHUNK:0]   sum_full;
  logic [WIDTH-1:0] result_next;
  logic             last_slice;
  logic             overflow_next;
  logic             zero_next;

  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = out_valid_reg;
  assign result     = result_reg;
  assign cout       = cout_reg;
  assign overflow   = overflow_reg;
  assign zero       = zero_reg;
  assign last_slice = (k_reg == KW'(N - 1));

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < N; i++) begin
      if (k_reg == KW'(i)) begin
        a_cur = a_reg[i*CHUNK +: CHUNK];
        b_cur = b_reg[i*CHUNK +: CHUNK];
      end
    end
    sum_full = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};
  end

  // Only the active slice is replaced; the others keep their earlier partial sums.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign result_next[gi*CHUNK +: CHUNK] =
        (k_reg == KW'(gi)) ? sum_full[CHUNK-1:0] : result_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // b_reg already holds ~op_b in subtract mode, so one rule covers both modes.
  assign overflow_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (result_next[WIDTH-1] != a_reg[WIDTH-1]);
  assign zero_next     = ~|result_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      k_reg         <= '0;
      result_reg    <= '0;
      cout_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub;
            k_reg     <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          result_reg <= result_next;
          carry_reg  <= sum_full[CHUNK];
          if (last_slice) begin
            cout_reg      <= sum_full[CHUNK];
            overflow_reg  <= overflow_next;
            zero_reg      <= zero_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
